// File: rtl/p2_sprite_pkg.sv
// Shared definitions for the player-2 sprite reader: action codes, sprite
// geometry and the field layout of the sprite ROM address.
package p2_sprite_pkg;

    typedef enum logic [2:0] {
        ACT_STAY  = 3'd0,
        ACT_FWD   = 3'd1,
        ACT_BWD   = 3'd2,
        ACT_PUNCH = 3'd3,
        ACT_KICK  = 3'd4
    } action_e;

    typedef enum logic {
        ST_IDLE,
        ST_PLAY
    } anim_state_e;

    localparam int SPR_W   = 16;  // sprite is SPR_W x SPR_W pixels
    localparam int FRAMES  = 4;   // frames per animation
    localparam int ROW_LSB = 6;   // rom_addr[9:6] = bitmap row
    localparam int ACT_LSB = 3;   // rom_addr[5:3] = action
    localparam int FRM_LSB = 0;   // rom_addr[2:0] = frame

    // Requests 1..4 start a one-shot animation; 0 and 5..7 do nothing.
    function automatic logic is_one_shot(input logic [2:0] req);
        return (req >= ACT_FWD) && (req <= ACT_KICK);
    endfunction

endpackage

// File: rtl/p2_anim_seq.sv
// Animation sequencer: picks the action and frame shown by the sprite.
// Everything advances only on frame_tick, so the picture never changes
// mid-frame. IDLE loops the stay animation; PLAY runs one pass of the
// requested action and then pulses anim_done.
module p2_anim_seq
    import p2_sprite_pkg::*;
#(
    parameter int FRAME_DIV = 6
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       frame_tick,
    input  logic [2:0] action_req,
    output logic [2:0] action,
    output logic [2:0] frame,
    output logic       anim_done
);

    localparam int               DIV_W      = 6;
    localparam logic [DIV_W-1:0] DIV_LAST   = DIV_W'(FRAME_DIV - 1);
    localparam logic [2:0]       FRAME_LAST = 3'(FRAMES - 1);

    anim_state_e      state;
    logic [DIV_W-1:0] div;

    // Tick divider, frame counter and IDLE/PLAY state, all registered.
    // NOTE: state uses non-blocking assignments so every register in this block
    // sees the pre-edge values of the others.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            action    <= ACT_STAY;
            frame     <= 3'd0;
            div       <= '0;
            anim_done <= 1'b0;
        end else begin
            anim_done <= 1'b0;
            if (frame_tick) begin
                case (state)
                    ST_IDLE: begin
                        if (is_one_shot(action_req)) begin
                            action <= action_req;
                            frame  <= 3'd0;
                            div    <= '0;
                            state  <= ST_PLAY;
                        end else if (div == DIV_LAST) begin
                            div   <= '0;
                            frame <= (frame == FRAME_LAST) ? 3'd0 : frame + 3'd1;
                        end else begin
                            div <= div + 1'b1;
                        end
                    end
                    ST_PLAY: begin
                        if (div == DIV_LAST) begin
                            div <= '0;
                            if (frame == FRAME_LAST) begin
                                action    <= ACT_STAY;
                                frame     <= 3'd0;
                                anim_done <= 1'b1;
                                state     <= ST_IDLE;
                            end else begin
                                frame <= frame + 3'd1;
                            end
                        end else begin
                            div <= div + 1'b1;
                        end
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule

// File: rtl/p2_sprite_render.sv
// Player-2 sprite renderer: turns the scan position into a sprite ROM
// address, absorbs the ROMs' one-cycle address register and produces the
// per-pixel colour two clocks after the scan position is presented.
module p2_sprite_render
    import p2_sprite_pkg::*;
#(
    parameter int SCALE_LOG2 = 2,
    parameter int FRAME_DIV  = 6,
    parameter int COORD_W    = 10
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [COORD_W-1:0] pix_x,
    input  logic [COORD_W-1:0] pix_y,
    input  logic               video_on,
    input  logic               frame_tick,
    input  logic [COORD_W-1:0] pos_x,
    input  logic [COORD_W-1:0] pos_y,
    input  logic [2:0]         action_req,
    input  logic               face_left,
    output logic [9:0]         rom_addr,
    input  logic [15:0]        rom_r,
    input  logic [15:0]        rom_g,
    input  logic [15:0]        rom_b,
    output logic               pix_on,
    output logic [2:0]         pix_rgb,
    output logic               anim_done
);

    localparam logic [COORD_W:0] BOX_SZ = (COORD_W + 1)'(SPR_W << SCALE_LOG2);

    logic [2:0]       action;
    logic [2:0]       frame;
    logic [COORD_W:0] dx;
    logic [COORD_W:0] dy;
    logic             in_box;
    logic [3:0]       row;
    logic [3:0]       col;
    logic             in_box_d;
    logic [3:0]       idx_d;
    logic             r;
    logic             g;
    logic             b;
    logic             lit;

    p2_anim_seq #(
        .FRAME_DIV (FRAME_DIV)
    ) u_anim_seq (
        .clk        (clk),
        .rst_n      (rst_n),
        .frame_tick (frame_tick),
        .action_req (action_req),
        .action     (action),
        .frame      (frame),
        .anim_done  (anim_done)
    );

    // One extra bit makes a scan position left of / above the sprite show up
    // as a set MSB instead of wrapping into the box.
    assign dx = {1'b0, pix_x} - {1'b0, pos_x};
    assign dy = {1'b0, pix_y} - {1'b0, pos_y};

    assign in_box = video_on & ~dx[COORD_W] & ~dy[COORD_W]
                  & (dx < BOX_SZ) & (dy < BOX_SZ);
    assign row    = dy[SCALE_LOG2 +: 4];
    assign col    = dx[SCALE_LOG2 +: 4];

    // ROM address: row forced to 0 outside the box to keep the lookup quiet.
    // NOTE: every output of this block gets a default first, so no latch can form.
    always_comb begin
        rom_addr                = '0;
        rom_addr[ROW_LSB +: 4]  = in_box ? row : 4'd0;
        rom_addr[ACT_LSB +: 3]  = action;
        rom_addr[FRM_LSB +: 3]  = frame;
    end

    // Stage 1: hold the box flag and bit index while the ROMs fetch the row.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_box_d <= 1'b0;
            idx_d    <= 4'd0;
        end else begin
            in_box_d <= in_box;
            idx_d    <= face_left ? col : 4'(SPR_W - 1) - col;
        end
    end

    // Plane bits are active-low: a 0 in the bitmap lights that channel.
    always_comb begin
        r   = ~rom_r[idx_d];
        g   = ~rom_g[idx_d];
        b   = ~rom_b[idx_d];
        lit = in_box_d & (r | g | b);
    end

    // Stage 2: register the final pixel for the video mixer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pix_on  <= 1'b0;
            pix_rgb <= 3'b000;
        end else begin
            pix_on  <= lit;
            pix_rgb <= lit ? {r, g, b} : 3'b000;
        end
    end

endmodule

// File: tb/tb_p2_sprite_render.sv
// Bench for p2_sprite_render: random sprite ROM contents behind a one-cycle
// registered ROM model, directed and random scan/animation stimulus, and a
// reference built from plain integer geometry and tick counting.
module tb_p2_sprite_render;

    localparam int SCALE_LOG2 = 2;
    localparam int FRAME_DIV  = 6;
    localparam int COORD_W    = 10;
    localparam int BOX        = 16 << SCALE_LOG2;
    localparam int PLAY_TICKS = 4 * FRAME_DIV;

    logic               clk;
    logic               rst_n;
    logic [COORD_W-1:0] pix_x, pix_y, pos_x, pos_y;
    logic               video_on, frame_tick, face_left;
    logic [2:0]         action_req;
    logic [9:0]         rom_addr;
    logic [15:0]        rom_r, rom_g, rom_b;
    logic               pix_on, anim_done;
    logic [2:0]         pix_rgb;

    p2_sprite_render #(
        .SCALE_LOG2 (SCALE_LOG2),
        .FRAME_DIV  (FRAME_DIV),
        .COORD_W    (COORD_W)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .pix_x      (pix_x),
        .pix_y      (pix_y),
        .video_on   (video_on),
        .frame_tick (frame_tick),
        .pos_x      (pos_x),
        .pos_y      (pos_y),
        .action_req (action_req),
        .face_left  (face_left),
        .rom_addr   (rom_addr),
        .rom_r      (rom_r),
        .rom_g      (rom_g),
        .rom_b      (rom_b),
        .pix_on     (pix_on),
        .pix_rgb    (pix_rgb),
        .anim_done  (anim_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Sprite ROMs with a registered address, as the real block ROMs behave.
    logic [15:0] mem_r [1024];
    logic [15:0] mem_g [1024];
    logic [15:0] mem_b [1024];

    always @(posedge clk) begin
        rom_r <= mem_r[rom_addr];
        rom_g <= mem_g[rom_addr];
        rom_b <= mem_b[rom_addr];
    end

    int checks = 0;
    int errors = 0;
    int done_seen = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Animation reference: counts ticks since entering the current mode.
    bit m_play;
    int m_act;
    int m_play_ticks;
    int m_idle_ticks;
    bit m_done;

    function automatic int m_frame();
        return m_play ? m_play_ticks / FRAME_DIV : (m_idle_ticks / FRAME_DIV) % 4;
    endfunction

    function automatic int m_action();
        return m_play ? m_act : 0;
    endfunction

    typedef struct {
        bit         on;
        logic [2:0] rgb;
    } pix_t;

    pix_t exp_q[$];

    // Expected ROM address and pixel for the inputs presented right now.
    task automatic compute_ref(output int addr, output pix_t p);
        int   dx, dy, row, col, idx;
        bit   inb;
        logic r, g, b;
        dx   = int'(pix_x) - int'(pos_x);
        dy   = int'(pix_y) - int'(pos_y);
        inb  = video_on && dx >= 0 && dy >= 0 && dx < BOX && dy < BOX;
        row  = inb ? dy / (1 << SCALE_LOG2) : 0;
        col  = inb ? dx / (1 << SCALE_LOG2) : 0;
        addr = row * 64 + m_action() * 8 + m_frame();
        idx  = face_left ? col : 15 - col;
        r    = ~mem_r[addr][idx];
        g    = ~mem_g[addr][idx];
        b    = ~mem_b[addr][idx];
        p.on  = inb && (r || g || b);
        p.rgb = p.on ? {r, g, b} : 3'b000;
    endtask

    // One clock: check at the falling edge, advance the model after the rising edge.
    task automatic step();
        int   addr;
        pix_t p, o;
        @(negedge clk);
        compute_ref(addr, p);
        check("rom_addr", rom_addr, addr);
        o = exp_q.pop_front();
        check("pix_on", pix_on, o.on);
        check("pix_rgb", pix_rgb, o.rgb);
        check("anim_done", anim_done, m_done);
        if (anim_done) done_seen++;
        exp_q.push_back(p);
        @(posedge clk);
        m_done = 1'b0;
        if (frame_tick) begin
            if (m_play) begin
                m_play_ticks++;
                if (m_play_ticks == PLAY_TICKS) begin
                    m_play       = 1'b0;
                    m_idle_ticks = 0;
                    m_done       = 1'b1;
                end
            end else if (action_req >= 3'd1 && action_req <= 3'd4) begin
                m_play       = 1'b1;
                m_act        = int'(action_req);
                m_play_ticks = 0;
            end else begin
                m_idle_ticks++;
            end
        end
        #1;
    endtask

    // Asynchronous reset pulse placed between clock edges.
    task automatic do_reset();
        pix_t z;
        z.on  = 1'b0;
        z.rgb = 3'b000;
        rst_n = 1'b0;
        #1;
        check("rst_pix_on", pix_on, 1'b0);
        check("rst_pix_rgb", pix_rgb, 3'b000);
        check("rst_anim_done", anim_done, 1'b0);
        check("rst_addr_low", rom_addr[5:0], 6'd0);
        m_play       = 1'b0;
        m_act        = 0;
        m_play_ticks = 0;
        m_idle_ticks = 0;
        m_done       = 1'b0;
        exp_q.delete();
        exp_q.push_back(z);
        exp_q.push_back(z);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic set_pix(input int x, input int y);
        pix_x = COORD_W'(x);
        pix_y = COORD_W'(y);
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) begin
            mem_r[i] = 16'($urandom);
            mem_g[i] = 16'($urandom);
            mem_b[i] = 16'($urandom);
        end
        rst_n      = 1'b1;
        video_on   = 1'b1;
        frame_tick = 1'b0;
        face_left  = 1'b0;
        action_req = 3'd0;
        pos_x      = 10'd100;
        pos_y      = 10'd50;
        set_pix(100, 50);
        @(posedge clk);
        #1;
        do_reset();

        // Sprite origin, far corner, just outside, and a far-away sprite.
        set_pix(100, 50);
        #1;
        check("addr_origin", rom_addr, 10'o0000);
        repeat (3) step();
        set_pix(163, 110);
        #1;
        check("addr_corner_row", rom_addr[9:6], 4'd15);
        repeat (3) step();
        set_pix(164, 50); step();
        set_pix(99, 50);  step();
        set_pix(100, 49); step();
        pos_x = 10'd1000;
        set_pix(10, 50);  step();
        repeat (2) step();
        pos_x = 10'd100;

        // Mirrored sprite: left edge reads bit 0, right edge bit 15.
        face_left = 1'b1;
        set_pix(100, 60); step();
        set_pix(163, 60); step();
        set_pix(131, 77); step();
        repeat (2) step();
        face_left = 1'b0;

        // Idle animation: frame steps once per FRAME_DIV ticks.
        frame_tick = 1'b1;
        repeat (FRAME_DIV) step();
        frame_tick = 1'b0;
        #1;
        check("idle_frame1", rom_addr[2:0], 3'd1);
        step();

        // Punch request: waits for a tick, runs 24 ticks, ignores a kick request.
        do_reset();
        action_req = 3'd3;
        repeat (3) step();
        check("punch_waits_tick", rom_addr[5:0], 6'o00);
        frame_tick = 1'b1;
        step();
        action_req = 3'd4;
        done_seen  = 0;
        for (int t = 0; t < PLAY_TICKS; t++) begin
            set_pix(100 + (t % 64), 50 + t);
            step();
        end
        frame_tick = 1'b0;
        action_req = 3'd0;
        step();
        check("done_pulses", done_seen, 1);
        #1;
        check("back_idle", rom_addr[5:0], 6'o00);
        step();

        // Reset while playing frame 2: no completion pulse, back to idle.
        do_reset();
        action_req = 3'd2;
        frame_tick = 1'b1;
        step();
        action_req = 3'd0;
        repeat (2 * FRAME_DIV + 1) step();
        frame_tick = 1'b0;
        set_pix(110, 60);
        #1;
        check("play_frame2", rom_addr[5:0], 6'o22);
        repeat (3) step();
        done_seen = 0;
        do_reset();
        repeat (4) step();
        check("no_done_after_rst", done_seen, 0);

        // Random scan positions, ticks and requests.
        for (int n = 0; n < 600; n++) begin
            if (n % 40 == 0) begin
                pos_x = COORD_W'($urandom_range(0, 1023));
                pos_y = COORD_W'($urandom_range(0, 1023));
            end
            if ($urandom_range(0, 7) == 0) begin
                set_pix($urandom_range(0, 1023), $urandom_range(0, 1023));
            end else begin
                set_pix((int'(pos_x) + $urandom_range(0, BOX + 15) - 8) & 1023,
                        (int'(pos_y) + $urandom_range(0, BOX + 15) - 8) & 1023);
            end
            video_on   = ($urandom_range(0, 7) != 0);
            face_left  = 1'($urandom_range(0, 1));
            frame_tick = ($urandom_range(0, 2) == 0);
            action_req = 3'($urandom_range(0, 7));
            step();
        end
        frame_tick = 1'b0;
        repeat (3) step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
